// File: rtl/id_ex_issue_if.sv
// ID/EX bundle: the decoded instruction from ID and the issued operands/controls to EX.
interface id_ex_issue_if #(
    parameter int XLEN       = 32,
    parameter int RADDR_W    = 5,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3,
    parameter int HOLD_CNT_W = 8
);
    logic [ALUOP_W-1:0]    id_aluop;
    logic [ALUSEL_W-1:0]   id_alusel;
    logic [XLEN-1:0]       id_opv1;
    logic [XLEN-1:0]       id_opv2;
    logic [RADDR_W-1:0]    id_rs1;
    logic [RADDR_W-1:0]    id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [RADDR_W-1:0]    id_reg_waddr;
    logic                  id_we;

    logic [ALUOP_W-1:0]    ex_aluop;
    logic [ALUSEL_W-1:0]   ex_alusel;
    logic [XLEN-1:0]       ex_opv1;
    logic [XLEN-1:0]       ex_opv2;
    logic [RADDR_W-1:0]    ex_reg_waddr;
    logic                  ex_we;
    logic                  ex_valid;
    logic [HOLD_CNT_W-1:0] hold_cnt;

    modport master (
        output id_aluop, id_alusel, id_opv1, id_opv2, id_rs1, id_rs2,
               id_rs1_used, id_rs2_used, id_reg_waddr, id_we,
        input  ex_aluop, ex_alusel, ex_opv1, ex_opv2, ex_reg_waddr, ex_we,
               ex_valid, hold_cnt
    );

    modport slave (
        input  id_aluop, id_alusel, id_opv1, id_opv2, id_rs1, id_rs2,
               id_rs1_used, id_rs2_used, id_reg_waddr, id_we,
        output ex_aluop, ex_alusel, ex_opv1, ex_opv2, ex_reg_waddr, ex_we,
               ex_valid, hold_cnt
    );
endinterface

// File: rtl/id_ex_issue.sv
// ID/EX pipeline register with EX/MEM/WB operand forwarding, bubble insertion on
// ID stall or flush, and operand refresh from WB while EX holds the instruction.
module id_ex_issue #(
    parameter int XLEN       = 32,
    parameter int RADDR_W    = 5,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3,
    parameter int HOLD_CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    id_ex_issue_if.slave       bus,
    input  logic               stall_id,
    input  logic               stall_ex,
    input  logic               flush,
    input  logic               ex_fwd_we,
    input  logic [RADDR_W-1:0] ex_fwd_waddr,
    input  logic [XLEN-1:0]    ex_fwd_wdata,
    input  logic               mem_fwd_we,
    input  logic [RADDR_W-1:0] mem_fwd_waddr,
    input  logic [XLEN-1:0]    mem_fwd_wdata,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_waddr,
    input  logic [XLEN-1:0]    wb_wdata
);

    typedef struct packed {
        logic [ALUOP_W-1:0]  aluop;
        logic [ALUSEL_W-1:0] alusel;
        logic [XLEN-1:0]     opv1;
        logic [XLEN-1:0]     opv2;
        logic [RADDR_W-1:0]  reg_waddr;
        logic                we;
        logic                valid;
        logic [RADDR_W-1:0]  rs1;
        logic [RADDR_W-1:0]  rs2;
        logic                rs1_used;
        logic                rs2_used;
    } issue_t;

    issue_t                issue_q;
    issue_t                load_bundle;
    logic [HOLD_CNT_W-1:0] hold_q;
    logic                  wb_hit1;
    logic                  wb_hit2;

    // Youngest producer wins: EX result beats MEM, which beats the WB write.
    function automatic logic [XLEN-1:0] forward_operand(
        input logic               used,
        input logic [RADDR_W-1:0] rs,
        input logic [XLEN-1:0]    regval
    );
        if (!used || rs == '0)
            return regval;
        if (ex_fwd_we && ex_fwd_waddr == rs)
            return ex_fwd_wdata;
        if (mem_fwd_we && mem_fwd_waddr == rs)
            return mem_fwd_wdata;
        if (wb_we && wb_waddr == rs)
            return wb_wdata;
        return regval;
    endfunction

    always_comb begin
        load_bundle           = '0;
        load_bundle.aluop     = bus.id_aluop;
        load_bundle.alusel    = bus.id_alusel;
        load_bundle.opv1      = forward_operand(bus.id_rs1_used, bus.id_rs1, bus.id_opv1);
        load_bundle.opv2      = forward_operand(bus.id_rs2_used, bus.id_rs2, bus.id_opv2);
        load_bundle.reg_waddr = bus.id_reg_waddr;
        load_bundle.we        = bus.id_we;
        load_bundle.valid     = 1'b1;
        load_bundle.rs1       = bus.id_rs1;
        load_bundle.rs2       = bus.id_rs2;
        load_bundle.rs1_used  = bus.id_rs1_used;
        load_bundle.rs2_used  = bus.id_rs2_used;
    end

    // A held instruction must still see a value retiring to its source register.
    assign wb_hit1 = issue_q.rs1_used && issue_q.rs1 != '0 && wb_we && wb_waddr == issue_q.rs1;
    assign wb_hit2 = issue_q.rs2_used && issue_q.rs2 != '0 && wb_we && wb_waddr == issue_q.rs2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q <= '0;
            hold_q  <= '0;
        end else if (flush) begin
            issue_q <= '0;
            hold_q  <= '0;
        end else if (stall_ex) begin
            if (wb_hit1)
                issue_q.opv1 <= wb_wdata;
            if (wb_hit2)
                issue_q.opv2 <= wb_wdata;
            if (hold_q != '1)
                hold_q <= hold_q + HOLD_CNT_W'(1);
        end else if (stall_id) begin
            issue_q <= '0;
            hold_q  <= '0;
        end else begin
            issue_q <= load_bundle;
            hold_q  <= '0;
        end
    end

    assign bus.ex_aluop     = issue_q.aluop;
    assign bus.ex_alusel    = issue_q.alusel;
    assign bus.ex_opv1      = issue_q.opv1;
    assign bus.ex_opv2      = issue_q.opv2;
    assign bus.ex_reg_waddr = issue_q.reg_waddr;
    assign bus.ex_we        = issue_q.we;
    assign bus.ex_valid     = issue_q.valid;
    assign bus.hold_cnt     = hold_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// Self-checking bench for id_ex_issue: directed scenarios plus randomized traffic
// compared against a behavioural model of the issue register.
module tb_id_ex_issue;
    localparam int XLEN       = 32;
    localparam int RADDR_W    = 5;
    localparam int ALUOP_W    = 8;
    localparam int ALUSEL_W   = 3;
    localparam int HOLD_CNT_W = 8;
    localparam int HOLD_MAX   = 255;

    logic clk;
    logic rst_n;
    logic stall_id, stall_ex, flush;
    logic ex_fwd_we, mem_fwd_we, wb_we;
    logic [RADDR_W-1:0] ex_fwd_waddr, mem_fwd_waddr, wb_waddr;
    logic [XLEN-1:0]    ex_fwd_wdata, mem_fwd_wdata, wb_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what EX should see after the last edge
    logic [ALUOP_W-1:0]  m_aluop;
    logic [ALUSEL_W-1:0] m_alusel;
    logic [XLEN-1:0]     m_opv1, m_opv2;
    logic [RADDR_W-1:0]  m_waddr, m_rs1, m_rs2;
    logic                m_we, m_valid, m_used1, m_used2;
    int                  m_hold;

    id_ex_issue_if #(.XLEN(XLEN), .RADDR_W(RADDR_W), .ALUOP_W(ALUOP_W),
                     .ALUSEL_W(ALUSEL_W), .HOLD_CNT_W(HOLD_CNT_W)) bus ();

    id_ex_issue #(.XLEN(XLEN), .RADDR_W(RADDR_W), .ALUOP_W(ALUOP_W),
                  .ALUSEL_W(ALUSEL_W), .HOLD_CNT_W(HOLD_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .stall_id(stall_id), .stall_ex(stall_ex), .flush(flush),
        .ex_fwd_we(ex_fwd_we), .ex_fwd_waddr(ex_fwd_waddr), .ex_fwd_wdata(ex_fwd_wdata),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_waddr(mem_fwd_waddr), .mem_fwd_wdata(mem_fwd_wdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [89:0] dut_vec();
        return {bus.ex_aluop, bus.ex_alusel, bus.ex_opv1, bus.ex_opv2,
                bus.ex_reg_waddr, bus.ex_we, bus.ex_valid, bus.hold_cnt};
    endfunction

    function automatic logic [89:0] model_vec();
        return {m_aluop, m_alusel, m_opv1, m_opv2, m_waddr, m_we, m_valid, 8'(m_hold)};
    endfunction

    // Scan producers from youngest to oldest; first matching writer supplies the value
    function automatic logic [XLEN-1:0] ref_operand(input logic used, input logic [RADDR_W-1:0] rs,
                                                    input logic [XLEN-1:0] regval);
        logic               src_we[3];
        logic [RADDR_W-1:0] src_wa[3];
        logic [XLEN-1:0]    src_wd[3];
        src_we = '{ex_fwd_we, mem_fwd_we, wb_we};
        src_wa = '{ex_fwd_waddr, mem_fwd_waddr, wb_waddr};
        src_wd = '{ex_fwd_wdata, mem_fwd_wdata, wb_wdata};
        if (!used || rs == 0) return regval;
        for (int i = 0; i < 3; i++)
            if (src_we[i] && src_wa[i] == rs) return src_wd[i];
        return regval;
    endfunction

    task automatic model_bubble();
        {m_aluop, m_alusel, m_opv1, m_opv2, m_waddr, m_we, m_valid} = '0;
        {m_rs1, m_rs2, m_used1, m_used2} = '0;
        m_hold = 0;
    endtask

    task automatic model_advance();
        if (flush || (!stall_ex && stall_id)) begin
            model_bubble();
        end else if (stall_ex) begin
            if (m_used1 && m_rs1 != 0 && wb_we && wb_waddr == m_rs1) m_opv1 = wb_wdata;
            if (m_used2 && m_rs2 != 0 && wb_we && wb_waddr == m_rs2) m_opv2 = wb_wdata;
            m_hold = (m_hold + 1 > HOLD_MAX) ? HOLD_MAX : m_hold + 1;
        end else begin
            m_aluop  = bus.id_aluop;
            m_alusel = bus.id_alusel;
            m_opv1   = ref_operand(bus.id_rs1_used, bus.id_rs1, bus.id_opv1);
            m_opv2   = ref_operand(bus.id_rs2_used, bus.id_rs2, bus.id_opv2);
            m_waddr  = bus.id_reg_waddr;
            m_we     = bus.id_we;
            m_valid  = 1'b1;
            m_rs1    = bus.id_rs1;
            m_rs2    = bus.id_rs2;
            m_used1  = bus.id_rs1_used;
            m_used2  = bus.id_rs2_used;
            m_hold   = 0;
        end
    endtask

    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {stall_id, stall_ex, flush} = '0;
        {ex_fwd_we, ex_fwd_waddr, ex_fwd_wdata} = '0;
        {mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata} = '0;
        {wb_we, wb_waddr, wb_wdata} = '0;
        bus.id_aluop = '0; bus.id_alusel = '0; bus.id_opv1 = '0; bus.id_opv2 = '0;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
        bus.id_reg_waddr = '0; bus.id_we = 1'b0;
    endtask

    task automatic random_id();
        bus.id_aluop     = ALUOP_W'($urandom);
        bus.id_alusel    = ALUSEL_W'($urandom);
        bus.id_opv1      = $urandom;
        bus.id_opv2      = $urandom;
        bus.id_rs1       = RADDR_W'($urandom_range(0, 7));
        bus.id_rs2       = RADDR_W'($urandom_range(0, 7));
        bus.id_rs1_used  = 1'($urandom);
        bus.id_rs2_used  = 1'($urandom);
        bus.id_reg_waddr = RADDR_W'($urandom);
        bus.id_we        = 1'($urandom);
    endtask

    task automatic random_fwd();
        ex_fwd_we  = 1'($urandom); ex_fwd_waddr  = RADDR_W'($urandom_range(0, 7)); ex_fwd_wdata  = $urandom;
        mem_fwd_we = 1'($urandom); mem_fwd_waddr = RADDR_W'($urandom_range(0, 7)); mem_fwd_wdata = $urandom;
        wb_we      = 1'($urandom); wb_waddr      = RADDR_W'($urandom_range(0, 7)); wb_wdata      = $urandom;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_bubble();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("[TB] FAIL reset: got %h expected %h", dut_vec(), model_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_load();
        clear_inputs();
        bus.id_aluop = 8'h20; bus.id_alusel = 3'b100;
        bus.id_opv1 = 32'd5; bus.id_opv2 = 32'd7;
        bus.id_reg_waddr = 5'd3; bus.id_we = 1'b1;
        step();
        n_checks++;
        if (dut_vec() !== model_vec() || bus.ex_opv1 !== 32'd5 || bus.ex_opv2 !== 32'd7
            || bus.ex_valid !== 1'b1 || bus.ex_reg_waddr !== 5'd3) begin
            n_fail++;
            $display("[TB] FAIL basic_load: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        bus.id_opv1 = 32'h1111; bus.id_rs1 = 5'd4; bus.id_rs1_used = 1'b1;
        ex_fwd_we = 1'b1;  ex_fwd_waddr = 5'd4;  ex_fwd_wdata = 32'hAA;
        mem_fwd_we = 1'b1; mem_fwd_waddr = 5'd4; mem_fwd_wdata = 32'hBB;
        step();
        n_checks++;
        if (bus.ex_opv1 !== 32'hAA || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("[TB] FAIL fwd_ex_over_mem: got opv1 %h expected %h", bus.ex_opv1, 32'hAA);
        end
        bus.id_rs1 = 5'd0; ex_fwd_waddr = 5'd0; mem_fwd_waddr = 5'd0;
        step();
        n_checks++;
        if (bus.ex_opv1 !== 32'h1111 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("[TB] FAIL fwd_x0: got opv1 %h expected %h", bus.ex_opv1, 32'h1111);
        end
        // Operand 1 from MEM and operand 2 from WB in the same cycle
        clear_inputs();
        bus.id_rs1 = 5'd2; bus.id_rs1_used = 1'b1; bus.id_opv1 = 32'h1;
        bus.id_rs2 = 5'd6; bus.id_rs2_used = 1'b1; bus.id_opv2 = 32'h2;
        mem_fwd_we = 1'b1; mem_fwd_waddr = 5'd2; mem_fwd_wdata = 32'hCAFE;
        wb_we = 1'b1;      wb_waddr = 5'd6;      wb_wdata = 32'hBEEF;
        step();
        n_checks++;
        if (bus.ex_opv1 !== 32'hCAFE || bus.ex_opv2 !== 32'hBEEF || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("[TB] FAIL fwd_dual: got %h/%h expected cafe/beef", bus.ex_opv1, bus.ex_opv2);
        end
        // Immediate operand: rs2 matches but is not used
        bus.id_rs2_used = 1'b0;
        step();
        n_checks++;
        if (bus.ex_opv2 !== 32'h2 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("[TB] FAIL fwd_unused: got opv2 %h expected %h", bus.ex_opv2, 32'h2);
        end
    endtask

    task automatic test_stall_hold();
        logic [XLEN-1:0] exp_opv2[3];
        clear_inputs();
        bus.id_aluop = 8'h11; bus.id_opv1 = 32'h10; bus.id_opv2 = 32'h20;
        bus.id_rs2 = 5'd6; bus.id_rs2_used = 1'b1; bus.id_reg_waddr = 5'd9; bus.id_we = 1'b1;
        step();
        random_id();
        stall_ex = 1'b1;
        exp_opv2 = '{32'h20, 32'h55, 32'h55};
        for (int c = 0; c < 3; c++) begin
            {wb_we, wb_waddr, wb_wdata} = (c == 1) ? {1'b1, 5'd6, 32'h55} : '0;
            step();
            n_checks++;
            if (bus.hold_cnt !== 8'(c + 1) || bus.ex_opv2 !== exp_opv2[c]
                || bus.ex_opv1 !== 32'h10 || dut_vec() !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL stall_hold[%0d]: got %h expected %h", c, dut_vec(), model_vec());
            end
        end
        clear_inputs();
        bus.id_opv1 = 32'h77;
        step();
        n_checks++;
        if (bus.hold_cnt !== 8'd0 || bus.ex_opv1 !== 32'h77 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("[TB] FAIL stall_release: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_bubble();
        clear_inputs();
        random_id();
        step();
        random_id();
        stall_id = 1'b1;
        step();
        n_checks++;
        if (dut_vec() !== 90'd0 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("[TB] FAIL stall_id_bubble: got %h expected 0", dut_vec());
        end
        stall_id = 1'b0;
        step();
        stall_ex = 1'b1;
        step();
        flush = 1'b1;
        step();
        n_checks++;
        if (dut_vec() !== 90'd0 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("[TB] FAIL flush_over_stall_ex: got %h expected 0", dut_vec());
        end
    endtask

    task automatic test_saturation();
        clear_inputs();
        random_id();
        step();
        stall_ex = 1'b1;
        for (int c = 0; c < 300; c++) begin
            random_fwd();
            random_id();
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL saturate[%0d]: got %h expected %h", c, dut_vec(), model_vec());
            end
        end
        n_checks++;
        if (bus.hold_cnt !== 8'd255) begin
            n_fail++;
            $display("[TB] FAIL saturate_final: got %0d expected 255", bus.hold_cnt);
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        random_id();
        step();
        stall_ex = 1'b1;
        repeat (4) step();
        #3;
        rst_n = 1'b0;
        model_bubble();
        #1;
        n_checks++;
        if (dut_vec() !== 90'd0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %h expected 0", dut_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        stall_ex = 1'b0;
        random_id();
        step();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("[TB] FAIL reset_resume: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        clear_inputs();
        for (int c = 0; c < 400; c++) begin
            random_id();
            random_fwd();
            flush    = ($urandom_range(0, 9) == 0);
            stall_ex = ($urandom_range(0, 3) == 0);
            stall_id = ($urandom_range(0, 4) == 0);
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL random[%0d]: got %h expected %h", c, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_forwarding();
        test_stall_hold();
        test_bubble();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
